load_store_unit: RTL and testbench

LOAD_STORE_UNIT -- requirements
Module: load_store_unit

---
 rtl/load_store_unit_pkg.sv | 36 +++
 rtl/load_align.sv | 33 +++
 rtl/load_store_unit.sv | 129 ++++++++++++
 tb/tb_load_store_unit.sv | 439 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/load_store_unit_pkg.sv
// Shared definitions for the load/store unit: data width, FSM encoding,
// RV32I funct3 width codes and the access legality check.
package load_store_unit_pkg;

    localparam int unsigned DATA_WIDTH = 32;

    typedef enum logic [1:0] {
        StIdle,
        StReq,
        StResp,
        StDone
    } lsu_state_e;

    localparam logic [2:0] F3_BYTE   = 3'b000;
    localparam logic [2:0] F3_HALF   = 3'b001;
    localparam logic [2:0] F3_WORD   = 3'b010;
    localparam logic [2:0] F3_BYTE_U = 3'b100;
    localparam logic [2:0] F3_HALF_U = 3'b101;

    // Unsigned widths exist only for loads; halves need even, words need aligned addresses.
    function automatic logic access_legal(input logic       is_load,
                                          input logic [2:0] funct3,
                                          input logic [1:0] offset);
        logic ok;
        case (funct3)
            F3_BYTE:   ok = 1'b1;
            F3_HALF:   ok = !offset[0];
            F3_WORD:   ok = (offset == 2'b00);
            F3_BYTE_U: ok = is_load;
            F3_HALF_U: ok = is_load && !offset[0];
            default:   ok = 1'b0;
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/load_align.sv
// Extracts the addressed byte/halfword from a read word and sign- or
// zero-extends it according to funct3. Purely combinational.
module load_align
    import load_store_unit_pkg::*;
(
    input  logic [DATA_WIDTH-1:0] rdata,
    input  logic [1:0]            offset,
    input  logic [2:0]            funct3,
    output logic [DATA_WIDTH-1:0] data
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    // Lane selection followed by width/sign extension.
    always_comb begin
        case (offset)
            2'b00:   byte_sel = rdata[7:0];
            2'b01:   byte_sel = rdata[15:8];
            2'b10:   byte_sel = rdata[23:16];
            default: byte_sel = rdata[31:24];
        endcase
        half_sel = offset[1] ? rdata[31:16] : rdata[15:0];
        case (funct3)
            F3_BYTE:   data = {{(DATA_WIDTH - 8){byte_sel[7]}}, byte_sel};
            F3_HALF:   data = {{(DATA_WIDTH - 16){half_sel[15]}}, half_sel};
            F3_BYTE_U: data = {{(DATA_WIDTH - 8){1'b0}}, byte_sel};
            F3_HALF_U: data = {{(DATA_WIDTH - 16){1'b0}}, half_sel};
            default:   data = rdata;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit: accepts one memory op from EX/MEM, runs a req/gnt and
// rvalid handshake on the data bus, and returns the extended load result.
module load_store_unit
    import load_store_unit_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  ex_valid_i,
    input  logic                  mem_read_i,
    input  logic                  mem_write_i,
    input  logic [2:0]            mem_funct3_i,
    input  logic [DATA_WIDTH-1:0] addr_i,
    input  logic [DATA_WIDTH-1:0] store_data_i,
    output logic                  dmem_req_o,
    output logic                  dmem_we_o,
    output logic [DATA_WIDTH-1:0] dmem_addr_o,
    output logic [3:0]            dmem_be_o,
    output logic [DATA_WIDTH-1:0] dmem_wdata_o,
    input  logic                  dmem_gnt_i,
    input  logic                  dmem_rvalid_i,
    input  logic [DATA_WIDTH-1:0] dmem_rdata_i,
    output logic [DATA_WIDTH-1:0] load_data_o,
    output logic                  done_o,
    output logic                  stall_o,
    output logic                  access_err_o
);

    lsu_state_e            state_q, state_d;
    logic                  accept, legal;
    logic                  is_load_q;
    logic [2:0]            funct3_q;
    logic [DATA_WIDTH-1:0] addr_q, wdata_q, load_data_q, aligned_data;
    logic                  err_q;
    logic [3:0]            lane_be;

    assign accept = ex_valid_i && (mem_read_i || mem_write_i);
    // A set mem_read_i wins when both op bits are raised.
    assign legal  = access_legal(mem_read_i, mem_funct3_i, addr_i[1:0]);

    load_align u_load_align (
        .rdata  (dmem_rdata_i),
        .offset (addr_q[1:0]),
        .funct3 (funct3_q),
        .data   (aligned_data)
    );

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) state_q <= StIdle;
        else     state_q <= state_d;
    end

    // Captures the accepted op, the error pulse and completed load data.
    always_ff @(posedge clk) begin
        if (rst) begin
            is_load_q   <= 1'b0;
            funct3_q    <= 3'b000;
            addr_q      <= '0;
            wdata_q     <= '0;
            load_data_q <= '0;
            err_q       <= 1'b0;
        end else begin
            err_q <= (state_q == StIdle) && accept && !legal;
            if (state_q == StIdle && accept) begin
                is_load_q <= mem_read_i;
                funct3_q  <= mem_funct3_i;
                addr_q    <= addr_i;
                wdata_q   <= store_data_i;
            end
            if (state_q == StResp && dmem_rvalid_i) load_data_q <= aligned_data;
        end
    end

    // Next-state logic; gnt and rvalid only matter in their own states.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: if (accept && legal) state_d = StReq;
            StReq:  if (dmem_gnt_i) state_d = is_load_q ? StResp : StDone;
            StResp: if (dmem_rvalid_i) state_d = StDone;
            StDone: state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // Byte enables and lane-replicated store data from the registered op.
    always_comb begin
        case (funct3_q[1:0])
            2'b00: begin
                lane_be      = 4'b0001 << addr_q[1:0];
                dmem_wdata_o = {4{wdata_q[7:0]}};
            end
            2'b01: begin
                lane_be      = addr_q[1] ? 4'b1100 : 4'b0011;
                dmem_wdata_o = {2{wdata_q[15:0]}};
            end
            default: begin
                lane_be      = 4'b1111;
                dmem_wdata_o = wdata_q;
            end
        endcase
    end

    // FSM outputs.
    always_comb begin
        dmem_req_o = 1'b0;
        dmem_we_o  = 1'b0;
        dmem_be_o  = 4'b0000;
        stall_o    = 1'b0;
        done_o     = 1'b0;
        unique case (state_q)
            StIdle: stall_o = accept && legal;
            StReq: begin
                dmem_req_o = 1'b1;
                dmem_we_o  = !is_load_q;
                dmem_be_o  = lane_be;
                stall_o    = 1'b1;
            end
            StResp: stall_o = 1'b1;
            StDone: done_o  = 1'b1;
            default: ;
        endcase
    end

    assign dmem_addr_o  = {addr_q[DATA_WIDTH-1:2], 2'b00};
    assign load_data_o  = load_data_q;
    assign access_err_o = err_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit with a queue-based scoreboard.
module tb_load_store_unit;
    import load_store_unit_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        ex_valid_i, mem_read_i, mem_write_i;
    logic [2:0]  mem_funct3_i;
    logic [31:0] addr_i, store_data_i;
    logic        dmem_req_o, dmem_we_o;
    logic [31:0] dmem_addr_o, dmem_wdata_o;
    logic [3:0]  dmem_be_o;
    logic        dmem_gnt_i, dmem_rvalid_i;
    logic [31:0] dmem_rdata_i, load_data_o;
    logic        done_o, stall_o, access_err_o;

    int checks = 0;
    int fails  = 0;

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [3:0]  be;
        logic [31:0] wdata;
        logic [31:0] ld;
        int          lat;
    } exp_t;
    exp_t exp_q[$];

    typedef struct {
        logic        acc_stall;
        int          req_cyc;
        logic        stable;
        logic        stall_ok;
        logic        stall_late;
        logic [31:0] addr;
        logic [3:0]  be;
        logic        we;
        logic [31:0] wdata;
        int          done_lat;
        int          done_cnt;
        logic [31:0] ld;
        int          err_cnt;
        int          err_cyc;
    } obs_t;

    load_store_unit dut (
        .clk          (clk),
        .rst          (rst),
        .ex_valid_i   (ex_valid_i),
        .mem_read_i   (mem_read_i),
        .mem_write_i  (mem_write_i),
        .mem_funct3_i (mem_funct3_i),
        .addr_i       (addr_i),
        .store_data_i (store_data_i),
        .dmem_req_o   (dmem_req_o),
        .dmem_we_o    (dmem_we_o),
        .dmem_addr_o  (dmem_addr_o),
        .dmem_be_o    (dmem_be_o),
        .dmem_wdata_o (dmem_wdata_o),
        .dmem_gnt_i   (dmem_gnt_i),
        .dmem_rvalid_i(dmem_rvalid_i),
        .dmem_rdata_i (dmem_rdata_i),
        .load_data_o  (load_data_o),
        .done_o       (done_o),
        .stall_o      (stall_o),
        .access_err_o (access_err_o)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // Reference models, written as shifts/multiplies.
    function automatic logic [31:0] model_load(input logic [2:0] f3, input logic [1:0] off,
                                               input logic [31:0] rd);
        logic [31:0] sh;
        sh = rd >> (8 * off);
        case (f3)
            3'b000:  return {{24{sh[7]}}, sh[7:0]};
            3'b001:  return {{16{sh[15]}}, sh[15:0]};
            3'b100:  return {24'h0, sh[7:0]};
            3'b101:  return {16'h0, sh[15:0]};
            default: return rd;
        endcase
    endfunction

    function automatic logic [3:0] model_be(input logic [2:0] f3, input logic [1:0] off);
        case (f3[1:0])
            2'b00:   return 4'b0001 << off;
            2'b01:   return 4'b0011 << off;
            default: return 4'b1111;
        endcase
    endfunction

    function automatic logic [31:0] model_wdata(input logic [2:0] f3, input logic [31:0] sd);
        case (f3[1:0])
            2'b00:   return {24'h0, sd[7:0]} * 32'h0101_0101;
            2'b01:   return {16'h0, sd[15:0]} * 32'h0001_0001;
            default: return sd;
        endcase
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs;
        ex_valid_i    = 1'b0;
        mem_read_i    = 1'b0;
        mem_write_i   = 1'b0;
        dmem_gnt_i    = 1'b0;
        dmem_rvalid_i = 1'b0;
    endtask

    // Drives one op and a bus responder; records what the DUT did, compares nothing.
    task automatic run_op(input logic ld, input logic [2:0] f3, input logic [31:0] a,
                          input logic [31:0] sd, input int gnt_dly, input logic [31:0] rd,
                          output obs_t o);
        logic resp;
        resp = 1'b0;
        o = '{1'b0, 0, 1'b1, 1'b1, 1'b0, 32'h0, 4'h0, 1'b0, 32'h0, -1, 0, 32'h0, 0, -1};
        ex_valid_i   = 1'b1;
        mem_read_i   = ld;
        mem_write_i  = !ld;
        mem_funct3_i = f3;
        addr_i       = a;
        store_data_i = sd;
        #1;
        o.acc_stall = stall_o;
        for (int cyc = 1; cyc <= gnt_dly + 10; cyc++) begin
            tick();
            idle_inputs();
            if (resp) begin
                dmem_rvalid_i = 1'b1;
                dmem_rdata_i  = rd;
                resp          = 1'b0;
            end
            #1;
            if (stall_o) o.stall_late = 1'b1;
            if (access_err_o) begin
                o.err_cnt++;
                if (o.err_cyc < 0) o.err_cyc = cyc;
            end
            if (o.done_lat < 0 && !done_o && !stall_o) o.stall_ok = 1'b0;
            if (done_o && stall_o) o.stall_ok = 1'b0;
            if (done_o) begin
                o.done_cnt++;
                if (o.done_lat < 0) begin
                    o.done_lat = cyc;
                    o.ld       = load_data_o;
                end
            end
            if (dmem_req_o) begin
                if (o.req_cyc == 0) begin
                    o.addr  = dmem_addr_o;
                    o.be    = dmem_be_o;
                    o.we    = dmem_we_o;
                    o.wdata = dmem_wdata_o;
                end else if (o.addr !== dmem_addr_o || o.be !== dmem_be_o ||
                             o.we !== dmem_we_o || o.wdata !== dmem_wdata_o) begin
                    o.stable = 1'b0;
                end
                o.req_cyc++;
                if (o.req_cyc > gnt_dly) begin
                    dmem_gnt_i = 1'b1;
                    if (ld) resp = 1'b1;
                end
            end
        end
        idle_inputs();
    endtask

    task automatic test_reset;
        rst = 1'b1;
        idle_inputs();
        mem_funct3_i = 3'b000;
        addr_i       = 32'h0;
        store_data_i = 32'h0;
        dmem_rdata_i = 32'h0;
        tick();
        tick();
        rst = 1'b0;
        #1;
        checks++;
        if ({dmem_req_o, dmem_we_o, done_o, stall_o, access_err_o, dmem_be_o} !== 9'h0) begin
            fails++;
            $display("FAIL reset_ctrl: got req/we/done/stall/err/be=%b want 0",
                     {dmem_req_o, dmem_we_o, done_o, stall_o, access_err_o, dmem_be_o});
        end
        checks++;
        if (dmem_addr_o !== 32'h0 || dmem_wdata_o !== 32'h0) begin
            fails++;
            $display("FAIL reset_bus: got addr=%h wdata=%h want 0", dmem_addr_o, dmem_wdata_o);
        end
        checks++;
        if (load_data_o !== 32'h0) begin
            fails++;
            $display("FAIL reset_load_data: got %h want 0", load_data_o);
        end
        // A stray grant while idle must not start anything.
        tick();
        dmem_gnt_i = 1'b1;
        tick();
        dmem_gnt_i = 1'b0;
        #1;
        checks++;
        if (dmem_req_o !== 1'b0 || stall_o !== 1'b0 || done_o !== 1'b0) begin
            fails++;
            $display("FAIL idle_gnt_ignored: got req=%b stall=%b done=%b want 0",
                     dmem_req_o, stall_o, done_o);
        end
    endtask

    task automatic test_store;
        obs_t o;
        exp_t e;
        logic [2:0]  f3s[3] = '{3'b010, 3'b000, 3'b001};
        logic [31:0] as[3]  = '{32'h100, 32'h103, 32'h102};
        logic [31:0] sds[3] = '{32'hDEAD_BEEF, 32'h0000_00AB, 32'h5555_1234};
        exp_q.push_back('{1'b1, 32'h100, 4'b1111, 32'hDEAD_BEEF, 32'h0, 2});
        exp_q.push_back('{1'b1, 32'h100, 4'b1000, 32'hABAB_ABAB, 32'h0, 2});
        exp_q.push_back('{1'b1, 32'h100, 4'b1100, 32'h1234_1234, 32'h0, 2});
        for (int i = 0; i < 3; i++) begin
            run_op(1'b0, f3s[i], as[i], sds[i], 0, 32'h0, o);
            e = exp_q.pop_front();
            checks++;
            if (o.addr !== e.addr || o.be !== e.be || o.we !== e.we || o.wdata !== e.wdata) begin
                fails++;
                $display("FAIL store%0d_bus: got addr=%h be=%b we=%b wdata=%h want %h %b %b %h",
                         i, o.addr, o.be, o.we, o.wdata, e.addr, e.be, e.we, e.wdata);
            end
            checks++;
            if (o.req_cyc !== 1 || o.done_lat !== e.lat || o.done_cnt !== 1) begin
                fails++;
                $display("FAIL store%0d_timing: got req_cyc=%0d done_lat=%0d done_cnt=%0d want 1 %0d 1",
                         i, o.req_cyc, o.done_lat, o.done_cnt, e.lat);
            end
            checks++;
            if (o.acc_stall !== 1'b1 || o.stall_ok !== 1'b1) begin
                fails++;
                $display("FAIL store%0d_stall: got accept_stall=%b profile_ok=%b want 1 1",
                         i, o.acc_stall, o.stall_ok);
            end
        end
    endtask

    task automatic test_load_ext;
        obs_t o;
        exp_t e;
        logic [2:0]  f3s[5] = '{3'b000, 3'b100, 3'b101, 3'b001, 3'b010};
        logic [31:0] as[5]  = '{32'h102, 32'h102, 32'h102, 32'h102, 32'h100};
        exp_q.push_back('{1'b0, 32'h100, 4'b0100, 32'h0, 32'hFFFF_FFFF, 3});
        exp_q.push_back('{1'b0, 32'h100, 4'b0100, 32'h0, 32'h0000_00FF, 3});
        exp_q.push_back('{1'b0, 32'h100, 4'b1100, 32'h0, 32'h0000_80FF, 3});
        exp_q.push_back('{1'b0, 32'h100, 4'b1100, 32'h0, 32'hFFFF_80FF, 3});
        exp_q.push_back('{1'b0, 32'h100, 4'b1111, 32'h0, 32'h80FF_7F00, 3});
        for (int i = 0; i < 5; i++) begin
            run_op(1'b1, f3s[i], as[i], 32'h0, 0, 32'h80FF_7F00, o);
            e = exp_q.pop_front();
            checks++;
            if (o.ld !== e.ld) begin
                fails++;
                $display("FAIL load%0d_data: got %h want %h", i, o.ld, e.ld);
            end
            checks++;
            if (o.addr !== e.addr || o.we !== e.we || o.done_lat !== e.lat || o.done_cnt !== 1) begin
                fails++;
                $display("FAIL load%0d_bus: got addr=%h we=%b lat=%0d dones=%0d want %h %b %0d 1",
                         i, o.addr, o.we, o.done_lat, o.done_cnt, e.addr, e.we, e.lat);
            end
        end
        // load_data_o holds after a store completes.
        run_op(1'b0, 3'b010, 32'h40, 32'h1111_2222, 0, 32'h0, o);
        checks++;
        if (load_data_o !== 32'h80FF_7F00) begin
            fails++;
            $display("FAIL load_data_hold: got %h want 80ff7f00", load_data_o);
        end
    endtask

    task automatic test_misaligned;
        obs_t o;
        logic        lds[4] = '{1'b1, 1'b0, 1'b1, 1'b0};
        logic [2:0]  f3s[4] = '{3'b001, 3'b010, 3'b011, 3'b100};
        logic [31:0] as[4]  = '{32'h101, 32'h102, 32'h100, 32'h100};
        for (int i = 0; i < 4; i++) begin
            run_op(lds[i], f3s[i], as[i], 32'hCAFE_F00D, 0, 32'h0, o);
            checks++;
            if (o.err_cnt !== 1 || o.err_cyc !== 1) begin
                fails++;
                $display("FAIL illegal%0d_err: got pulses=%0d first_cycle=%0d want 1 1",
                         i, o.err_cnt, o.err_cyc);
            end
            checks++;
            if (o.req_cyc !== 0 || o.done_cnt !== 0 || o.stall_late !== 1'b0) begin
                fails++;
                $display("FAIL illegal%0d_quiet: got req_cyc=%0d dones=%0d late_stall=%b want 0 0 0",
                         i, o.req_cyc, o.done_cnt, o.stall_late);
            end
        end
    endtask

    task automatic test_gnt_delay;
        obs_t o;
        exp_t e;
        exp_q.push_back('{1'b0, 32'h200, 4'b1111, 32'h0, 32'h1234_5678, 6});
        run_op(1'b1, 3'b010, 32'h200, 32'h0, 3, 32'h1234_5678, o);
        e = exp_q.pop_front();
        checks++;
        if (o.req_cyc !== 4 || o.stable !== 1'b1 || o.addr !== e.addr || o.be !== e.be) begin
            fails++;
            $display("FAIL gnt_delay_req: got cycles=%0d stable=%b addr=%h be=%b want 4 1 %h %b",
                     o.req_cyc, o.stable, o.addr, o.be, e.addr, e.be);
        end
        checks++;
        if (o.stall_ok !== 1'b1 || o.acc_stall !== 1'b1) begin
            fails++;
            $display("FAIL gnt_delay_stall: got profile_ok=%b accept_stall=%b want 1 1",
                     o.stall_ok, o.acc_stall);
        end
        checks++;
        if (o.done_cnt !== 1 || o.done_lat !== e.lat || o.ld !== e.ld) begin
            fails++;
            $display("FAIL gnt_delay_done: got dones=%0d lat=%0d data=%h want 1 %0d %h",
                     o.done_cnt, o.done_lat, o.ld, e.lat, e.ld);
        end
    endtask

    task automatic test_reset_mid;
        int dones;
        ex_valid_i   = 1'b1;
        mem_read_i   = 1'b1;
        mem_funct3_i = 3'b010;
        addr_i       = 32'h300;
        tick();
        idle_inputs();
        dmem_gnt_i = 1'b1;
        tick();
        dmem_gnt_i = 1'b0;
        rst        = 1'b1;
        #1;
        checks++;
        if (stall_o !== 1'b1 || dmem_req_o !== 1'b0) begin
            fails++;
            $display("FAIL resp_state: got stall=%b req=%b want 1 0", stall_o, dmem_req_o);
        end
        tick();
        rst = 1'b0;
        #1;
        checks++;
        if ({dmem_req_o, dmem_we_o, done_o, stall_o, access_err_o, dmem_be_o} !== 9'h0 ||
            dmem_addr_o !== 32'h0 || dmem_wdata_o !== 32'h0 || load_data_o !== 32'h0) begin
            fails++;
            $display("FAIL reset_mid_outputs: got ctrl=%b addr=%h wdata=%h ld=%h want all 0",
                     {dmem_req_o, dmem_we_o, done_o, stall_o, access_err_o, dmem_be_o},
                     dmem_addr_o, dmem_wdata_o, load_data_o);
        end
        dmem_rvalid_i = 1'b1;
        dmem_rdata_i  = 32'hFFFF_FFFF;
        dones = 0;
        for (int i = 0; i < 4; i++) begin
            tick();
            dmem_rvalid_i = 1'b0;
            #1;
            if (done_o) dones++;
        end
        checks++;
        if (dones !== 0 || load_data_o !== 32'h0) begin
            fails++;
            $display("FAIL reset_mid_rvalid_ignored: got dones=%0d ld=%h want 0 0", dones, load_data_o);
        end
    endtask

    task automatic test_back_to_back;
        obs_t        o;
        exp_t        e;
        logic        ld;
        logic [2:0]  f3;
        logic [1:0]  off;
        logic [31:0] a, sd, rd, last_ld;
        int          dly;
        logic [2:0]  ld_f3s[5] = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
        logic [2:0]  st_f3s[3] = '{3'b000, 3'b001, 3'b010};
        last_ld = load_data_o;
        for (int i = 0; i < 24; i++) begin
            ld  = 1'($urandom_range(0, 1));
            f3  = ld ? ld_f3s[$urandom_range(0, 4)] : st_f3s[$urandom_range(0, 2)];
            off = 2'($urandom_range(0, 3));
            if (f3[1:0] == 2'b01) off[0] = 1'b0;
            if (f3[1:0] == 2'b10) off = 2'b00;
            a   = {$urandom(), 2'b00} | {30'h0, off};
            sd  = $urandom();
            rd  = $urandom();
            dly = $urandom_range(0, 2);
            e.we    = !ld;
            e.addr  = {a[31:2], 2'b00};
            e.be    = model_be(f3, off);
            e.wdata = model_wdata(f3, sd);
            e.ld    = ld ? model_load(f3, off, rd) : last_ld;
            e.lat   = dly + (ld ? 3 : 2);
            exp_q.push_back(e);
            run_op(ld, f3, a, sd, dly, rd, o);
            e = exp_q.pop_front();
            checks++;
            if (o.addr !== e.addr || o.be !== e.be || o.we !== e.we ||
                (!ld && o.wdata !== e.wdata)) begin
                fails++;
                $display("FAIL b2b%0d_bus: got addr=%h be=%b we=%b wdata=%h want %h %b %b %h",
                         i, o.addr, o.be, o.we, o.wdata, e.addr, e.be, e.we, e.wdata);
            end
            checks++;
            if (o.ld !== e.ld || o.done_lat !== e.lat || o.done_cnt !== 1) begin
                fails++;
                $display("FAIL b2b%0d_done: got ld=%h lat=%0d dones=%0d want %h %0d 1",
                         i, o.ld, o.done_lat, o.done_cnt, e.ld, e.lat);
            end
            last_ld = e.ld;
        end
    endtask

    initial begin
        test_reset();
        test_store();
        test_load_ext();
        test_misaligned();
        test_gnt_delay();
        test_reset_mid();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
